// File: rtl/regfile_sb.sv
// Register file with per-register pending (scoreboard) bits, write-through read bypass,
// optional hardwired-zero register 0 and a registered copy of the top register.
module regfile_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 3,
  parameter int ZERO_R0 = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDR_W-1:0]        rd1_reg,
  input  logic [ADDR_W-1:0]        rd2_reg,
  output logic [DATA_W-1:0]        rd1_data,
  output logic [DATA_W-1:0]        rd2_data,
  output logic                     rd1_busy,
  output logic                     rd2_busy,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_reg,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     pend_en,
  input  logic [ADDR_W-1:0]        pend_reg,
  output logic [DATA_W-1:0]        special_q,
  output logic [(1<<ADDR_W)-1:0]   busy_vec
);
  localparam int N = 1 << ADDR_W;
  localparam int NPORT = 2;

  logic [N-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [N-1:0]             pend_q, pend_d;
  logic [DATA_W-1:0]        special_d;
  logic                     wr_ok, pend_ok;

  // Traffic aimed at a hardwired-zero r0 is dropped before it reaches storage.
  assign wr_ok   = wr_en   & ~((ZERO_R0 != 0) && (wr_reg   == '0));
  assign pend_ok = pend_en & ~((ZERO_R0 != 0) && (pend_reg == '0));

  // Set applied after clear so a same-cycle issue/writeback leaves the bit set.
  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    if (wr_ok) begin
      regs_d[wr_reg] = wr_data;
      pend_d[wr_reg] = 1'b0;
    end
    if (pend_ok) pend_d[pend_reg] = 1'b1;
    special_d = regs_d[N-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q    <= '0;
      pend_q    <= '0;
      special_q <= '0;
    end else begin
      regs_q    <= regs_d;
      pend_q    <= pend_d;
      special_q <= special_d;
    end
  end

  assign busy_vec = pend_q;

  logic [NPORT-1:0][ADDR_W-1:0] rd_reg;
  logic [NPORT-1:0][DATA_W-1:0] rd_data;
  logic [NPORT-1:0]             rd_busy;

  assign rd_reg = {rd2_reg, rd1_reg};

  for (genvar p = 0; p < NPORT; p++) begin : g_rd
    logic hit, zero;
    assign hit  = wr_ok && (wr_reg == rd_reg[p]);
    assign zero = (ZERO_R0 != 0) && (rd_reg[p] == '0);
    // A same-cycle pend is deliberately invisible here; only writeback bypasses.
    assign rd_data[p] = zero ? '0   : hit ? wr_data : regs_q[rd_reg[p]];
    assign rd_busy[p] = zero ? 1'b0 : (pend_q[rd_reg[p]] & ~hit);
  end

  assign rd1_data = rd_data[0];
  assign rd2_data = rd_data[1];
  assign rd1_busy = rd_busy[0];
  assign rd2_busy = rd_busy[1];
endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: two instances (ZERO_R0=0 and 1) sharing stimulus, compared each
// cycle against an array-based reference model, plus directed scenarios.
module tb_regfile_sb;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] rd1_reg = '0, rd2_reg = '0, wr_reg = '0, pend_reg = '0;
  logic          wr_en = 1'b0, pend_en = 1'b0;
  logic [DW-1:0] wr_data = '0;

  logic [1:0][DW-1:0] rd1_data, rd2_data, special_q;
  logic [1:0]         rd1_busy, rd2_busy;
  logic [1:0][N-1:0]  busy_vec;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(0)) u_a (
    .clk(clk), .rst_n(rst_n), .rd1_reg(rd1_reg), .rd2_reg(rd2_reg),
    .rd1_data(rd1_data[0]), .rd2_data(rd2_data[0]), .rd1_busy(rd1_busy[0]), .rd2_busy(rd2_busy[0]),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pend_en(pend_en), .pend_reg(pend_reg),
    .special_q(special_q[0]), .busy_vec(busy_vec[0]));

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1)) u_b (
    .clk(clk), .rst_n(rst_n), .rd1_reg(rd1_reg), .rd2_reg(rd2_reg),
    .rd1_data(rd1_data[1]), .rd2_data(rd2_data[1]), .rd1_busy(rd1_busy[1]), .rd2_busy(rd2_busy[1]),
    .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data), .pend_en(pend_en), .pend_reg(pend_reg),
    .special_q(special_q[1]), .busy_vec(busy_vec[1]));

  // Reference state: instance 0 is a plain file, instance 1 has r0 hardwired to zero.
  logic [DW-1:0] m_reg [2][N];
  bit            m_pend[2][N];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] e_rd(input int k, input logic [AW-1:0] r);
    if (k == 1 && r == 0) return '0;
    if (wr_en && wr_reg == r) return wr_data;
    return m_reg[k][r];
  endfunction

  function automatic logic e_busy(input int k, input logic [AW-1:0] r);
    if (k == 1 && r == 0) return 1'b0;
    if (wr_en && wr_reg == r) return 1'b0;
    return m_pend[k][r];
  endfunction

  function automatic logic [N-1:0] e_vec(input int k);
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_pend[k][i];
    return v;
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        if (!rst_n) begin
          m_reg[k][i] = '0; m_pend[k][i] = 0;
        end else if (!(k == 1 && i == 0)) begin
          if (wr_en && wr_reg == i) begin m_reg[k][i] = wr_data; m_pend[k][i] = 0; end
          if (pend_en && pend_reg == i) m_pend[k][i] = 1;
        end
      end
  endtask

  // Entered at a negedge with inputs set; checks comb outputs, clocks, checks registered outputs.
  task automatic cycle();
    #2;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("rd1_data[%0d]", k), 64'(rd1_data[k]), 64'(e_rd(k, rd1_reg)));
      chk($sformatf("rd2_data[%0d]", k), 64'(rd2_data[k]), 64'(e_rd(k, rd2_reg)));
      chk($sformatf("rd1_busy[%0d]", k), 64'(rd1_busy[k]), 64'(e_busy(k, rd1_reg)));
      chk($sformatf("rd2_busy[%0d]", k), 64'(rd2_busy[k]), 64'(e_busy(k, rd2_reg)));
    end
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("busy_vec[%0d]", k), 64'(busy_vec[k]), 64'(e_vec(k)));
      chk($sformatf("special_q[%0d]", k), 64'(special_q[k]), 64'(m_reg[k][N-1]));
    end
    @(negedge clk);
  endtask

  task automatic idle();
    wr_en = 1'b0; pend_en = 1'b0;
  endtask

  initial begin
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin m_reg[k][i] = 'x; m_pend[k][i] = 0; end
    @(negedge clk);
    rst_n = 1'b0; idle();
    cycle(); cycle();
    rst_n = 1'b1;

    // Post-reset: every index reads zero, nothing busy.
    for (int i = 0; i < N; i++) begin
      rd1_reg = AW'(i); rd2_reg = AW'(N-1-i);
      #1 chk("rst_rd1", 64'(rd1_data[0]), 64'h0);
      cycle();
    end
    chk("rst_busy_vec", 64'(busy_vec[0]), 64'h0);
    chk("rst_special", 64'(special_q[0]), 64'h0);

    // Write bypass visible same cycle, stored value next cycle.
    wr_en = 1'b1; wr_reg = 3'd3; wr_data = 32'hDEADBEEF; rd1_reg = 3'd3;
    #1 chk("byp_same", 64'(rd1_data[0]), 64'hDEADBEEF);
    cycle(); idle();
    #1 chk("byp_next", 64'(rd1_data[0]), 64'hDEADBEEF);
    cycle();

    // Pend r5, hold two idle cycles, then writeback clears it.
    pend_en = 1'b1; pend_reg = 3'd5; rd2_reg = 3'd5;
    cycle(); idle();
    cycle(); chk("pend_hold1", 64'(busy_vec[0]), 64'h20);
    cycle(); chk("pend_hold2", 64'(busy_vec[0]), 64'h20);
    wr_en = 1'b1; wr_reg = 3'd5; wr_data = 32'h12;
    #1 chk("pend_wr_busy", 64'(rd2_busy[0]), 64'h0);
    chk("pend_wr_vec", 64'(busy_vec[0]), 64'h20);
    cycle(); idle();
    #1 chk("pend_clr", 64'(busy_vec[0]), 64'h0);

    // Same-cycle pend and write on r4: data lands, bit stays set.
    pend_en = 1'b1; pend_reg = 3'd4; wr_en = 1'b1; wr_reg = 3'd4; wr_data = 32'h55;
    cycle(); idle(); rd1_reg = 3'd4;
    #1 chk("pw_data", 64'(rd1_data[0]), 64'h55);
    chk("pw_busy", 64'(busy_vec[0][4]), 64'h1);
    cycle();

    // Special register tracks r7; reset beats a concurrent write.
    wr_en = 1'b1; wr_reg = 3'd7; wr_data = 32'hA5A5A5A5;
    cycle(); idle();
    #1 chk("spec_wr", 64'(special_q[0]), 64'hA5A5A5A5);
    rst_n = 1'b0; wr_en = 1'b1; wr_reg = 3'd7; wr_data = 32'h1234;
    cycle(); rst_n = 1'b1; idle(); rd1_reg = 3'd7;
    #1 chk("spec_rst", 64'(special_q[0]), 64'h0);
    chk("spec_rst_rd", 64'(rd1_data[0]), 64'h0);
    cycle();

    // Hardwired r0 discards write and pend.
    wr_en = 1'b1; wr_reg = 3'd0; wr_data = 32'hFFFF; pend_en = 1'b1; pend_reg = 3'd0; rd1_reg = 3'd0;
    #1 chk("z0_rd", 64'(rd1_data[1]), 64'h0);
    chk("z0_busy", 64'(rd1_busy[1]), 64'h0);
    cycle(); idle();
    #1 chk("z0_vec", 64'(busy_vec[1][0]), 64'h0);
    chk("z0_rd_after", 64'(rd1_data[1]), 64'h0);
    cycle();

    // Randomised traffic, occasional reset.
    for (int t = 0; t < 400; t++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      wr_en    = $urandom_range(0, 1);
      pend_en  = $urandom_range(0, 1);
      wr_reg   = AW'($urandom_range(0, N-1));
      pend_reg = AW'($urandom_range(0, N-1));
      rd1_reg  = AW'($urandom_range(0, N-1));
      rd2_reg  = ($urandom_range(0, 3) == 0) ? rd1_reg : AW'($urandom_range(0, N-1));
      wr_data  = $urandom;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
